// File: rtl/cpu_pkg.sv
// Shared constants for the CPU memory subsystem: RAM geometry, the index of
// each requester port, and the arbiter's winner encoding.
package cpu_pkg;

  localparam int AW       = 12;  // RAM address width (4096 words)
  localparam int DW       = 16;  // RAM data width
  localparam int MAX_WAIT = 8;   // default starvation threshold for port D

  // Bit positions of each requester in per-port vectors (e.g. rd_owner).
  localparam int PORT_C = 0;
  localparam int PORT_D = 1;

  // Which requester owns the RAM in the current cycle.
  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_C    = 2'd1,
    WIN_D    = 2'd2
  } winner_e;

endpackage : cpu_pkg

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of the single-port program/data RAM.
// Port C (CPU) has fixed priority and can lock the RAM for read-modify-write.
// Port D (DMA/loader) is forced through after MAX_WAIT consecutive denials.
// One access is issued per cycle; read data returns exactly one cycle later
// to whichever port issued the read.
module ram_port_arbiter #(
  parameter int AW       = cpu_pkg::AW,
  parameter int DW       = cpu_pkg::DW,
  parameter int MAX_WAIT = cpu_pkg::MAX_WAIT
) (
  input  logic          clk,
  input  logic          rst_n,
  // CPU port
  input  logic          c_req,
  input  logic          c_we,
  input  logic          c_lock,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  // DMA port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  // RAM pins
  output logic          ram_en,
  output logic          ram_load,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  import cpu_pkg::*;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic       locked_q,   locked_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] rd_owner_q, rd_owner_d;
  logic       starve;
  winner_e    win;

  // Pick this cycle's winner: lock first, then starvation guard, then CPU priority.
  always_comb begin
    // NOTE: every always_comb output gets a default up front so no path can
    // leave it unassigned and infer a latch.
    win    = WIN_NONE;
    starve = (wait_cnt_q == WAIT_LIMIT);
    // NOTE: grants are gated by rst_n so nothing reaches the RAM while reset is
    // held, even though the request inputs may still be active.
    if (rst_n) begin
      if (locked_q) begin
        if (c_req) win = WIN_C;
      end else if (starve && d_req) begin
        win = WIN_D;
      end else if (c_req) begin
        win = WIN_C;
      end else if (d_req) begin
        win = WIN_D;
      end
    end
  end

  // Steer the winner's command onto the RAM pins; idle pins are driven to zero.
  always_comb begin
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    ram_en    = 1'b0;
    ram_load  = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (win)
      WIN_C: begin
        c_gnt    = 1'b1;
        ram_en   = ~c_we;
        ram_load = c_we;
        ram_addr = c_addr;
        if (c_we) ram_wdata = c_wdata;
      end
      WIN_D: begin
        d_gnt    = 1'b1;
        ram_en   = ~d_we;
        ram_load = d_we;
        ram_addr = d_addr;
        if (d_we) ram_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  // Next-state for the lock, the starvation counter and the read-return owner.
  always_comb begin
    // Lock is taken by a granted locked access and released as soon as c_lock drops.
    locked_d = c_lock & (locked_q | c_gnt);

    if (d_req && !d_gnt) begin
      wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = 8'd0;
    end

    rd_owner_d         = 2'b00;
    rd_owner_d[PORT_C] = c_gnt & ~c_we;
    rd_owner_d[PORT_D] = d_gnt & ~d_we;
  end

  // State registers; async reset drops the lock, the count and any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q   <= 1'b0;
      wait_cnt_q <= 8'd0;
      rd_owner_q <= 2'b00;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      locked_q   <= locked_d;
      wait_cnt_q <= wait_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Return registered RAM data to whichever port issued last cycle's read.
  always_comb begin
    c_rvalid = rd_owner_q[PORT_C];
    d_rvalid = rd_owner_q[PORT_D];
    c_rdata  = c_rvalid ? ram_rdata : '0;
    d_rdata  = d_rvalid ? ram_rdata : '0;
  end

endmodule : ram_port_arbiter

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a table of single-access vectors
// followed by hand-written multi-cycle sequences (reset mid-read, contention,
// lock, write-then-read, alternating reads). A behavioural RAM with a
// registered output sits on the RAM pins.
module tb_ram_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          c_req, c_we, c_lock;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt, c_rvalid;
  logic [DW-1:0] c_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          ram_en, ram_load;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [0:4095];

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_lock   (c_lock),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_gnt    (c_gnt),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .ram_en   (ram_en),
    .ram_load (ram_load),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Single-port RAM with registered read data.
  always @(posedge clk) begin
    if (ram_load) mem[ram_addr] <= ram_wdata;
    if (ram_en)   ram_rdata     <= mem[ram_addr];
  end

  typedef struct {
    logic          c_req, c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          e_c_gnt, e_d_gnt, e_en, e_load;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_c_rv;
    logic [DW-1:0] e_c_rd;
    logic          e_d_rv;
    logic [DW-1:0] e_d_rd;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of request inputs at the falling edge, settle 1 time unit.
  task automatic cyc(input logic cr, input logic cw, input logic cl,
                     input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                     input logic dr, input logic dw,
                     input logic [AW-1:0] da, input logic [DW-1:0] dd);
    @(negedge clk);
    c_req = cr; c_we = cw; c_lock = cl; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'hA000 | DW'(i);
    mem[12'h005] = 16'h1234;

    //             c_req we addr     wdata     d_req we addr     wdata     cg dg en ld e_addr   e_wdata   crv crd       drv drd
    vecs[0] = '{1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 0, 0, 0, 0, 12'h000, 16'h0000, 0, 16'h0000, 0, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 12'h005, 16'hFFFF, 1'b0, 1'b0, 12'h000, 16'h0000, 1, 0, 1, 0, 12'h005, 16'h0000, 1, 16'h1234, 0, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 12'h00A, 16'h5A5A, 1'b0, 1'b0, 12'h000, 16'h0000, 1, 0, 0, 1, 12'h00A, 16'h5A5A, 0, 16'h0000, 0, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h123, 16'h4444, 0, 1, 1, 0, 12'h123, 16'h0000, 0, 16'h0000, 1, 16'hA123};
    vecs[4] = '{1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'hFFE, 16'h7777, 0, 1, 0, 1, 12'hFFE, 16'h7777, 0, 16'h0000, 0, 16'h0000};
    vecs[5] = '{1'b1, 1'b0, 12'h010, 16'h0000, 1'b1, 1'b1, 12'h011, 16'h9999, 1, 0, 1, 0, 12'h010, 16'h0000, 1, 16'hA010, 0, 16'h0000};
    vecs[6] = '{1'b1, 1'b1, 12'h020, 16'h1111, 1'b1, 1'b0, 12'h030, 16'h0000, 1, 0, 0, 1, 12'h020, 16'h1111, 0, 16'h0000, 0, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 12'h00A, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1, 0, 1, 0, 12'h00A, 16'h0000, 1, 16'h5A5A, 0, 16'h0000};

    // ---- Reset state ----
    rst_n = 1'b0;
    c_req = 1; c_we = 0; c_lock = 0; c_addr = 12'h005; c_wdata = '0;
    d_req = 1; d_we = 0; d_addr = 12'h006; d_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_c_gnt",    c_gnt,    0);
    check("rst_d_gnt",    d_gnt,    0);
    check("rst_ram_en",   ram_en,   0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_c_rvalid", c_rvalid, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    c_req = 0; d_req = 0;

    // ---- Table-driven single accesses, each followed by an idle cycle ----
    for (int i = 0; i < 8; i++) begin
      cyc(vecs[i].c_req, vecs[i].c_we, 1'b0, vecs[i].c_addr, vecs[i].c_wdata,
          vecs[i].d_req, vecs[i].d_we, vecs[i].d_addr, vecs[i].d_wdata);
      check($sformatf("v%0d_c_gnt", i),     c_gnt,     vecs[i].e_c_gnt);
      check($sformatf("v%0d_d_gnt", i),     d_gnt,     vecs[i].e_d_gnt);
      check($sformatf("v%0d_ram_en", i),    ram_en,    vecs[i].e_en);
      check($sformatf("v%0d_ram_load", i),  ram_load,  vecs[i].e_load);
      check($sformatf("v%0d_ram_addr", i),  32'(ram_addr),  32'(vecs[i].e_addr));
      check($sformatf("v%0d_ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].e_wdata));
      idle();
      check($sformatf("v%0d_c_rvalid", i),  c_rvalid,  vecs[i].e_c_rv);
      check($sformatf("v%0d_c_rdata", i),   32'(c_rdata),   32'(vecs[i].e_c_rd));
      check($sformatf("v%0d_d_rvalid", i),  d_rvalid,  vecs[i].e_d_rv);
      check($sformatf("v%0d_d_rdata", i),   32'(d_rdata),   32'(vecs[i].e_d_rd));
    end

    // ---- Reset asserted while a read is in flight ----
    cyc(1, 0, 0, 12'h005, '0, 0, 0, '0, '0);
    check("mid_c_gnt", c_gnt, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_c_rvalid", c_rvalid, 0);
    check("mid_rst_c_gnt",    c_gnt,    0);
    check("mid_rst_ram_en",   ram_en,   0);
    @(negedge clk);
    c_req = 0;
    cyc(1, 0, 0, 12'h005, '0, 0, 0, '0, '0);
    rst_n = 1'b1;
    #1;
    check("rel_c_gnt",    c_gnt,    1);
    check("rel_c_rvalid", c_rvalid, 0);
    check("rel_ram_en",   ram_en,   1);
    idle();
    check("rel_rd_c_rvalid", c_rvalid, 1);
    check("rel_rd_c_rdata",  32'(c_rdata), 32'h1234);
    check("rel_rd_d_rvalid", d_rvalid, 0);

    // ---- Contention: D forced through every 9th cycle ----
    idle();
    for (int i = 0; i < 18; i++) begin
      logic exp_d;
      logic prev_d;
      exp_d  = (i % 9 == 8);
      prev_d = (i % 9 == 0) && (i != 0);
      cyc(1, 0, 0, 12'h001, '0, 1, 0, 12'h002, '0);
      check($sformatf("cont%0d_c_gnt", i), c_gnt, !exp_d);
      check($sformatf("cont%0d_d_gnt", i), d_gnt, exp_d);
      check($sformatf("cont%0d_d_rvalid", i), d_rvalid, prev_d);
      if (prev_d) check($sformatf("cont%0d_d_rdata", i), 32'(d_rdata), 32'hA002);
    end
    idle();

    // ---- Lock: D held off even once starved; released the cycle after unlock ----
    for (int i = 0; i < 10; i++) begin
      logic cr;
      cr = (i != 5);
      cyc(cr, 0, 1, 12'h003, '0, 1, 0, 12'h004, '0);
      check($sformatf("lock%0d_c_gnt", i), c_gnt, cr);
      check($sformatf("lock%0d_d_gnt", i), d_gnt, 0);
    end
    cyc(1, 0, 0, 12'h003, '0, 1, 0, 12'h004, '0);
    check("unlock0_c_gnt", c_gnt, 1);
    check("unlock0_d_gnt", d_gnt, 0);
    cyc(1, 0, 0, 12'h003, '0, 1, 0, 12'h004, '0);
    check("unlock1_c_gnt", c_gnt, 0);
    check("unlock1_d_gnt", d_gnt, 1);
    idle();
    check("unlock_d_rvalid", d_rvalid, 1);
    check("unlock_d_rdata",  32'(d_rdata), 32'hA004);
    idle();

    // ---- D writes 0x0FFF, C reads it back the next cycle ----
    cyc(0, 0, 0, '0, '0, 1, 1, 12'hFFF, 16'hBEEF);
    check("wr_d_gnt",     d_gnt,    1);
    check("wr_ram_load",  ram_load, 1);
    check("wr_ram_wdata", 32'(ram_wdata), 32'hBEEF);
    cyc(1, 0, 0, 12'hFFF, '0, 0, 0, '0, '0);
    check("rd_c_gnt",     c_gnt,    1);
    check("rd_d_rvalid",  d_rvalid, 0);
    idle();
    check("rd_c_rvalid",  c_rvalid, 1);
    check("rd_c_rdata",   32'(c_rdata), 32'hBEEF);

    // ---- Alternating readers on consecutive cycles ----
    cyc(1, 0, 0, 12'h010, '0, 0, 0, '0, '0);
    check("alt0_c_gnt", c_gnt, 1);
    cyc(0, 0, 0, '0, '0, 1, 0, 12'h011, '0);
    check("alt1_d_gnt",    d_gnt,    1);
    check("alt1_c_rvalid", c_rvalid, 1);
    check("alt1_c_rdata",  32'(c_rdata), 32'hA010);
    check("alt1_d_rvalid", d_rvalid, 0);
    cyc(1, 0, 0, 12'h012, '0, 0, 0, '0, '0);
    check("alt2_c_gnt",    c_gnt,    1);
    check("alt2_d_rvalid", d_rvalid, 1);
    check("alt2_d_rdata",  32'(d_rdata), 32'hA011);
    check("alt2_c_rvalid", c_rvalid, 0);
    check("alt2_c_rdata",  32'(c_rdata), 32'h0000);
    idle();
    check("alt3_c_rvalid", c_rvalid, 1);
    check("alt3_c_rdata",  32'(c_rdata), 32'hA012);
    check("alt3_d_rvalid", d_rvalid, 0);
    check("alt3_d_rdata",  32'(d_rdata), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_ram_port_arbiter
